phase_loader: RTL and testbench

PHASE_LOADER -- requirements
Module: phase_loader

---
 rtl/phase_loader_pkg.sv | 34 +++
 rtl/phase_loader_if.sv | 9 +
 rtl/phase_loader_inter_byte_timer.sv | 28 ++
 rtl/phase_loader.sv | 147 ++++++++++++++
 tb/tb_phase_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/phase_loader_pkg.sv
// rtl/phase_loader_pkg.sv - opcodes, FSM states and defaults for the phase loader
package phase_loader_pkg;

  localparam logic [7:0] OP_SET_OFFSET = 8'h01;
  localparam logic [7:0] OP_SET_DIVIDE = 8'h02;
  localparam logic [7:0] OP_COMMIT     = 8'h03;

  localparam logic [1:0] NARGS_SET_OFFSET = 2'd3;
  localparam logic [1:0] NARGS_SET_DIVIDE = 2'd2;
  localparam logic [1:0] NARGS_COMMIT     = 2'd0;

  // 40 kHz half-period terminal count at 50 MHz
  localparam int DEFAULT_DIVIDE = 624;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG,
    ST_EXEC,
    ST_PULSE
  } state_t;

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_SET_OFFSET) || (op == OP_SET_DIVIDE) || (op == OP_COMMIT);
  endfunction

  function automatic logic [1:0] op_nargs(input logic [7:0] op);
    case (op)
      OP_SET_OFFSET: return NARGS_SET_OFFSET;
      OP_SET_DIVIDE: return NARGS_SET_DIVIDE;
      default:       return NARGS_COMMIT;
    endcase
  endfunction

endpackage

// File: rtl/phase_loader_if.sv
// rtl/phase_loader_if.sv - host command byte stream into the phase loader
interface phase_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/phase_loader_inter_byte_timer.sv
// rtl/phase_loader_inter_byte_timer.sv - idle-cycle watchdog between argument bytes
module inter_byte_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = !load && !clear && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/phase_loader.sv
// rtl/phase_loader.sv - byte-command loader of shadowed channel offsets and clock divide
module phase_loader
  import phase_loader_pkg::*;
#(
  parameter int N_CH         = 16,
  parameter int OFFSET_WIDTH = 11,
  parameter int RST_CYCLES   = 4,
  parameter int TIMEOUT      = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  phase_loader_if.slave                rx,
  output logic [N_CH*OFFSET_WIDTH-1:0] offset_flat,
  output logic [OFFSET_WIDTH-2:0]      divide,
  output logic                         clk_rst_n,
  output logic                         err
);

  localparam int DW   = OFFSET_WIDTH - 1;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW   = $clog2(RST_CYCLES + 1);

  state_t                  state, state_n;
  logic [7:0]              opcode;
  logic [7:0]              args [3];
  logic [1:0]              arg_cnt, arg_cnt_n;
  logic [PW-1:0]           pulse_cnt, pulse_cnt_n;
  logic                    err_n;
  logic                    accept, expire, ch_ok;
  logic                    wr_offset, wr_divide, do_commit;
  logic [OFFSET_WIDTH-1:0] shadow_offset [N_CH];
  logic [OFFSET_WIDTH-1:0] active_offset [N_CH];
  logic [DW-1:0]           shadow_divide;

  assign rx.rx_ready = (state == ST_IDLE) || (state == ST_ARG);
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign clk_rst_n   = (state != ST_PULSE);
  assign ch_ok       = ({1'b0, args[0]} < 9'(N_CH));

  inter_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .clear  (state != ST_ARG),
    .expire (expire)
  );

  always_comb begin
    state_n     = state;
    arg_cnt_n   = arg_cnt;
    pulse_cnt_n = pulse_cnt;
    err_n       = 1'b0;
    wr_offset   = 1'b0;
    wr_divide   = 1'b0;
    do_commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!op_valid(rx.rx_data)) begin
            err_n = 1'b1;
          end else begin
            arg_cnt_n = '0;
            state_n   = (op_nargs(rx.rx_data) == 2'd0) ? ST_EXEC : ST_ARG;
          end
        end
      end
      ST_ARG: begin
        if (accept) begin
          if (arg_cnt == op_nargs(opcode) - 2'd1) begin
            state_n = ST_EXEC;
          end else begin
            arg_cnt_n = arg_cnt + 2'd1;
          end
        end else if (expire) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_n = ST_IDLE;
        case (opcode)
          OP_SET_OFFSET: begin
            if (ch_ok) wr_offset = 1'b1;
            else       err_n     = 1'b1;
          end
          OP_SET_DIVIDE: wr_divide = 1'b1;
          default: begin
            do_commit   = 1'b1;
            pulse_cnt_n = '0;
            state_n     = ST_PULSE;
          end
        endcase
      end
      ST_PULSE: begin
        if (pulse_cnt == PW'(RST_CYCLES - 1)) begin
          pulse_cnt_n = '0;
          state_n     = ST_IDLE;
        end else begin
          pulse_cnt_n = pulse_cnt + PW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Reset lands in PULSE so the clock bank preloads the reset-time values on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PULSE;
      arg_cnt   <= '0;
      pulse_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      arg_cnt   <= arg_cnt_n;
      pulse_cnt <= pulse_cnt_n;
      err       <= err_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode        <= '0;
      shadow_divide <= DW'(DEFAULT_DIVIDE);
      divide        <= DW'(DEFAULT_DIVIDE);
      for (int i = 0; i < 3; i++) args[i] <= '0;
      for (int k = 0; k < N_CH; k++) begin
        shadow_offset[k] <= '0;
        active_offset[k] <= '0;
      end
    end else begin
      if (state == ST_IDLE && accept && op_valid(rx.rx_data)) opcode <= rx.rx_data;
      if (state == ST_ARG && accept) args[arg_cnt] <= rx.rx_data;
      if (wr_offset) shadow_offset[args[0][CH_W-1:0]] <= OFFSET_WIDTH'({args[1], args[2]});
      if (wr_divide) shadow_divide <= DW'({args[0], args[1]});
      if (do_commit) begin
        active_offset <= shadow_offset;
        divide        <= shadow_divide;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign offset_flat[k*OFFSET_WIDTH +: OFFSET_WIDTH] = active_offset[k];
  end

endmodule

// File: tb/tb_phase_loader.sv
// tb/tb_phase_loader.sv - directed and randomized self-checking bench for phase_loader
module tb_phase_loader;

  localparam int N_CH = 16;
  localparam int OW   = 11;
  localparam int RC   = 4;
  localparam int TO   = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  phase_loader_if ifc ();
  logic [N_CH*OW-1:0] offset_flat;
  logic [OW-2:0]      divide;
  logic               clk_rst_n;
  logic               err;

  phase_loader #(.N_CH(N_CH), .OFFSET_WIDTH(OW), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (ifc),
    .offset_flat (offset_flat),
    .divide      (divide),
    .clk_rst_n   (clk_rst_n),
    .err         (err)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_sh [N_CH];
  int m_act [N_CH];
  int m_sdiv, m_adiv;

  int err_hi = 0, acc_cnt = 0;
  int low_run = 0, last_run = 0, n_pulses = 0;
  int rdy_run = 0, last_rdy_run = 0;

  always @(posedge clk) begin
    if (!rst) begin
      low_run = 0;
      rdy_run = 0;
    end else begin
      if (err) err_hi++;
      if (ifc.rx_valid && ifc.rx_ready) acc_cnt++;
      if (!clk_rst_n) low_run++;
      else if (low_run > 0) begin last_run = low_run; n_pulses++; low_run = 0; end
      if (!ifc.rx_ready) rdy_run++;
      else if (rdy_run > 0) begin last_rdy_run = rdy_run; rdy_run = 0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin m_sh[k] = 0; m_act[k] = 0; end
    m_sdiv = 624;
    m_adiv = 624;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    int n;
    n = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    while (!ifc.rx_ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(ifc.rx_ready), 1);
    @(negedge clk);
    if (!keep) ifc.rx_valid = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    for (int k = 0; k < N_CH; k++)
      chk($sformatf("%s_ch%0d", tag, k), 32'(offset_flat[k*OW +: OW]), m_act[k]);
    chk({tag, "_div"}, 32'(divide), m_adiv);
  endtask

  task automatic cmd_offset(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo);
    int e0;
    e0 = err_hi;
    send_byte(8'h01, 0); send_byte(ch, 0); send_byte(hi, 0); send_byte(lo, 0);
    settle(4);
    if (ch < N_CH) m_sh[ch] = int'({hi, lo}) & ((1 << OW) - 1);
    chk("offset_err", err_hi - e0, (ch >= N_CH) ? 1 : 0);
  endtask

  task automatic cmd_divide(input logic [7:0] hi, input logic [7:0] lo);
    int e0;
    e0 = err_hi;
    send_byte(8'h02, 0); send_byte(hi, 0); send_byte(lo, 0);
    settle(4);
    m_sdiv = int'({hi, lo}) & ((1 << (OW - 1)) - 1);
    chk("divide_err", err_hi - e0, 0);
  endtask

  task automatic cmd_commit();
    int p0;
    p0 = n_pulses;
    send_byte(8'h03, 0);
    settle(8);
    m_act  = m_sh;
    m_adiv = m_sdiv;
    chk("commit_pulses", n_pulses - p0, 1);
    chk("commit_pulse_len", last_run, RC);
    chk("commit_ready_low", last_rdy_run, RC + 1);
    chk_outputs("commit");
  endtask

  task automatic cmd_bad(input logic [7:0] op);
    int e0;
    e0 = err_hi;
    send_byte(op, 0);
    settle(3);
    chk("bad_op_err", err_hi - e0, 1);
    chk("bad_op_idle", 32'(ifc.rx_ready), 1);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a0, kind;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    model_reset();
    settle(3);
    chk("rst_clk_rst_n", 32'(clk_rst_n), 0);
    chk("rst_rx_ready", 32'(ifc.rx_ready), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_divide", 32'(divide), 624);
    chk("rst_offsets", 32'(|offset_flat), 0);
    rst = 1'b1;
    settle(8);
    chk("post_rst_pulses", n_pulses, 1);
    chk("post_rst_pulse_len", last_run, RC);
    chk("post_rst_ready", 32'(ifc.rx_ready), 1);
    chk_outputs("post_rst");

    // Out-of-range channel, then the documented example sequence
    cmd_offset(8'h10, 8'h00, 8'h01);
    cmd_commit();
    cmd_offset(8'h03, 8'h04, 8'h7F);
    cmd_divide(8'h01, 8'hF4);
    chk_outputs("pre_commit");
    cmd_commit();
    chk("ex_ch3", 32'(offset_flat[3*OW +: OW]), 32'h47F);
    chk("ex_div", 32'(divide), 32'h1F4);

    // Inter-byte timeout abort, then a slow-but-legal command just inside the limit
    e0 = err_hi;
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    settle(TO + 5);
    chk("timeout_err", err_hi - e0, 1);
    chk("timeout_idle", 32'(ifc.rx_ready), 1);
    cmd_commit();
    e0 = err_hi;
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    settle(TO - 2);
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    settle(4);
    m_sh[2] = 5;
    chk("slow_cmd_err", err_hi - e0, 0);
    cmd_commit();

    // Invalid opcode, then rx_valid held high across a COMMIT
    cmd_bad(8'h55);
    cmd_commit();
    a0 = acc_cnt;
    send_byte(8'h03, 1);
    m_act  = m_sh;
    m_adiv = m_sdiv;
    send_byte(8'h02, 1);
    chk("held_ready_low", last_rdy_run, RC + 1);
    send_byte(8'h00, 1); send_byte(8'h99, 0);
    settle(4);
    m_sdiv = 32'h099;
    chk("held_accepts", acc_cnt - a0, 4);
    chk_outputs("held");
    cmd_commit();

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: cmd_offset(8'($urandom_range(0, N_CH + 1)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)));
        2: cmd_divide(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        3: cmd_commit();
        default: cmd_bad(8'($urandom_range(4, 255)));
      endcase
      chk_outputs("rand");
    end

    // Reset in the middle of a resync pulse
    cmd_offset(8'h05, 8'h02, 8'h22);
    send_byte(8'h03, 0);
    settle(2);
    chk("mid_pulse_low", 32'(clk_rst_n), 0);
    a0 = n_pulses;
    rst = 1'b0;
    model_reset();
    settle(2);
    rst = 1'b1;
    settle(8);
    chk("rst2_pulses", n_pulses - a0, 1);
    chk("rst2_pulse_len", last_run, RC);
    chk_outputs("rst2");
    cmd_commit();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
